mem_arbiter: RTL and testbench

Two-master arbiter that shares the unified instruction/data memory port between the CORE data path (master 0) and a secondary bus master (master 1, e.g. program loader or DMA). It sits between the requesters and the memory-side address decoder. It grants one single-cycle transfer per clock using round-robin priority, with an optional locked burst bounded by `MAX_BURST`. Read data is registered and returned one cycle after the grant.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory-side decoder.
// The master modport is the requester/memory view; the slave modport is the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  m0_req;
  logic                  m0_we;
  logic                  m0_lock;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic                  m1_lock;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin memory arbiter with bounded locked bursts and registered read return.
// Optional grant/conflict counters are enabled by defining ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef ARB_STATS_EN
  output logic [15:0] m0_grant_cnt,
  output logic [15:0] m1_grant_cnt,
  output logic [15:0] conflict_cnt,
`endif
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  typedef enum logic [1:0] {OwnNone, OwnM0, OwnM1} owner_e;

  owner_e                owner_q;
  logic                  last_q;  // 1: M1 was granted last
  logic [CntW-1:0]       burst_cnt_q;
  logic                  m0_rvalid_q, m1_rvalid_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

  logic                  gnt0, gnt1;
  logic                  xfer, xfer_lock, other_req, same_owner;
  logic [CntW-1:0]       cnt_inc;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  mem_we_d;

  // Owner keeps priority only while it still requests; otherwise plain round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (owner_q == OwnM0 && bus.m0_req) begin
      gnt0 = 1'b1;
    end else if (owner_q == OwnM1 && bus.m1_req) begin
      gnt1 = 1'b1;
    end else if (bus.m0_req && bus.m1_req) begin
      if (last_q) gnt0 = 1'b1;
      else        gnt1 = 1'b1;
    end else if (bus.m0_req) begin
      gnt0 = 1'b1;
    end else if (bus.m1_req) begin
      gnt1 = 1'b1;
    end
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    xfer       = gnt0 | gnt1;
    xfer_lock  = gnt0 ? bus.m0_lock : bus.m1_lock;
    other_req  = gnt0 ? bus.m1_req : bus.m0_req;
    same_owner = (gnt0 && owner_q == OwnM0) || (gnt1 && owner_q == OwnM1);
    // A fresh owner starts counting at one; a continuing owner saturates at the limit.
    if (!same_owner)                cnt_inc = CntW'(1);
    else if (burst_cnt_q == MaxCnt) cnt_inc = MaxCnt;
    else                            cnt_inc = burst_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OwnNone;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      if (xfer) begin
        last_q <= gnt1;
        if (!xfer_lock || (cnt_inc == MaxCnt && other_req)) begin
          owner_q     <= OwnNone;
          burst_cnt_q <= '0;
        end else begin
          owner_q     <= gnt0 ? OwnM0 : OwnM1;
          burst_cnt_q <= cnt_inc;
        end
      end
      m0_rvalid_q <= gnt0 & ~bus.m0_we;
      m1_rvalid_q <= gnt1 & ~bus.m1_we;
      if (gnt0 && !bus.m0_we) m0_rdata_q <= bus.mem_rdata;
      if (gnt1 && !bus.m1_we) m1_rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    if (gnt0) begin
      mem_addr_d  = bus.m0_addr;
      mem_wdata_d = bus.m0_wdata;
      mem_we_d    = bus.m0_we;
    end else if (gnt1) begin
      mem_addr_d  = bus.m1_addr;
      mem_wdata_d = bus.m1_wdata;
      mem_we_d    = bus.m1_we;
    end
  end

  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_we    = mem_we_d;
  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0 && m0_grant_cnt != 16'hFFFF) m0_grant_cnt <= m0_grant_cnt + 16'd1;
      if (gnt1 && m1_grant_cnt != 16'hFFFF) m1_grant_cnt <= m1_grant_cnt + 16'd1;
      if (bus.m0_req && bus.m1_req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_BURST = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef ARB_STATS_EN
  logic [15:0] m0_grant_cnt, m1_grant_cnt, conflict_cnt;
`endif

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MAX_BURST (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef ARB_STATS_EN
    .m0_grant_cnt(m0_grant_cnt),
    .m1_grant_cnt(m1_grant_cnt),
    .conflict_cnt(conflict_cnt),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    bus.m0_req = 1; bus.m0_we = 1; bus.m1_req = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got=%b want=00", {bus.m1_gnt, bus.m0_gnt});
    end
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we);
    end
    checks++;
    if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid got=%b want=00", {bus.m1_rvalid, bus.m0_rvalid});
    end
    checks++;
    if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h want=0/0", bus.m0_rdata, bus.m1_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h0000_0010; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL read_gnt got=%b want=01", {bus.m1_gnt, bus.m0_gnt});
    end
    checks++;
    if (bus.mem_addr !== 32'h0000_0010 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL read_mem got=%h/%b want=00000010/0", bus.mem_addr, bus.mem_we);
    end
    @(negedge clk);
    bus.m0_req = 0; bus.mem_rdata = 32'h1111_2222;
    #1;
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_data got=%b/%h want=1/deadbeef", bus.m0_rvalid, bus.m0_rdata);
    end
    checks++;
    if (bus.m1_gnt !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL read_m1_idle got=%b/%b want=0/0", bus.m1_gnt, bus.m1_rvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_hold got=%b/%h want=0/deadbeef", bus.m0_rvalid, bus.m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_a [4]  = '{32'h100, 32'h200, 32'h100, 32'h200};
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h100;
    bus.m1_req = 1; bus.m1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_g[i]) begin
        errors++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, {bus.m1_gnt, bus.m0_gnt}, exp_g[i]);
      end
      checks++;
      if (bus.mem_addr !== exp_a[i]) begin
        errors++; $display("FAIL rr_addr[%0d] got=%h want=%h", i, bus.mem_addr, exp_a[i]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_burst_limit();
    logic [1:0] exp_g [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    // One solo M0 transfer leaves M0 as last, so M1 wins the next contention.
    bus.m0_req = 1;
    @(negedge clk);
    bus.m1_req = 1; bus.m1_lock = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_g[i]) begin
        errors++; $display("FAIL burst_gnt[%0d] got=%b want=%b", i, {bus.m1_gnt, bus.m0_gnt}, exp_g[i]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_locked_idle();
    int m0_hits = 0;
    do_reset();
    bus.m0_req = 1; bus.m0_lock = 1;
    for (int c = 1; c <= 9; c++) begin
      #1;
      if (bus.m0_gnt === 1'b1 && bus.m1_gnt === 1'b0) m0_hits++;
      @(negedge clk);
    end
    checks++;
    if (m0_hits !== 9) begin
      errors++; $display("FAIL lock_solo got=%0d want=9", m0_hits);
    end
    bus.m1_req = 1;
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL lock_c10 got=%b want=01", {bus.m1_gnt, bus.m0_gnt});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin
      errors++; $display("FAIL lock_c11 got=%b want=10", {bus.m1_gnt, bus.m0_gnt});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (bus.m1_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20
        || bus.mem_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL wr_mem got=%b/%b/%h/%h want=1/1/00000020/a5a5a5a5",
                         bus.m1_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    bus.m1_req = 0; bus.m1_we = 0;
    bus.m0_req = 1; bus.m0_lock = 1; bus.m0_addr = 32'h30; bus.mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (bus.m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL wr_no_rvalid got=%b want=0", bus.m1_rvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m0_rvalid !== 1'b1) begin
      errors++; $display("FAIL lockrd got=%b/%b want=1/1", bus.m0_gnt, bus.m0_rvalid);
    end
    @(negedge clk);
    bus.m1_req = 1; bus.m1_we = 1;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL midrst_gnt got=%b/%b want=00/0", {bus.m1_gnt, bus.m0_gnt}, bus.mem_we);
    end
    checks++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 32'h0) begin
      errors++; $display("FAIL midrst_rvalid got=%b/%h want=0/0", bus.m0_rvalid, bus.m0_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL midrst_first got=%b want=01", {bus.m1_gnt, bus.m0_gnt});
    end
    @(negedge clk);
    idle_inputs();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.m0_req = 1; bus.m1_req = 1;
    repeat (3) @(negedge clk);
    bus.m1_req = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (m0_grant_cnt !== 16'd4 || m1_grant_cnt !== 16'd1 || conflict_cnt !== 16'd3) begin
      errors++; $display("FAIL stats got=%0d/%0d/%0d want=4/1/3",
                         m0_grant_cnt, m1_grant_cnt, conflict_cnt);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_limit();
    test_locked_idle();
    test_reset_mid_burst();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
